// File: rtl/rv_core_pkg.sv
// Shared fetch-stage definitions: datapath width, the fetch FSM state type
// and the canonical NOP encoding.
package rv_core_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bus and the decode-side valid/ready
// port of the fetch stage, bundled for the fetch unit and its peers.
interface if_fetch_if #(
    parameter int XLEN = rv_core_pkg::XLEN
) ();

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_inst;
    logic            id_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output id_valid, id_pc, id_inst,
        input  id_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  id_valid, id_pc, id_inst,
        output id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular buffer of {pc, instruction} pairs between fetch and decode.
// Flush has priority over push/pop; the head is read straight from storage.
module fetch_fifo
    import rv_core_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 64,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] cnt
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    // next-state of pointers, occupancy and storage
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            cnt_d    = {CW{1'b0}};
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    // state registers; empty slots hold a NOP at pc 0
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= W'(INST_NOP);
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            cnt_q    <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = mem_q[rd_ptr_q];
    assign cnt  = cnt_q;

endmodule

// File: rtl/if_fetch_chk.sv
// Protocol checks for the fetch stage: no response may arrive while idle,
// and the PC stall must never mask a redirect.
module if_fetch_chk
    import rv_core_pkg::*;
(
    input logic         clk,
    input logic         rst,
    input fetch_state_t state,
    input logic         rvalid,
    input logic         jp_en,
    input logic         pc_stall
);

    // A reset taken with a request outstanding leaves one response orphaned;
    // it may legally show up while idle afterwards.
    logic orphan_q, orphan_d;

    // orphan tracking
    always_comb begin
        orphan_d = orphan_q;
        if (!rst) begin
            orphan_d = orphan_q || (state != IDLE);
        end else if (rvalid) begin
            orphan_d = 1'b0;
        end else begin
            orphan_d = orphan_q;
        end
    end

    // orphan register
    always_ff @(posedge clk) begin
        orphan_q <= orphan_d;
    end

    a_no_rvalid_idle: assert property (@(posedge clk) disable iff (!rst)
        !(rvalid && (state == IDLE) && !orphan_q));

    a_jump_not_stalled: assert property (@(posedge clk)
        jp_en |-> !pc_stall);

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: one outstanding imem request at a time, responses
// buffered with their PC for decode, redirect discards in-flight work.
module if_fetch #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_addr,
    output logic            pc_stall,
    input  logic            jp_en,
    if_fetch_if.master      bus
);

    import rv_core_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] r_pc_q, r_pc_d;
    logic            push_s, pop_s, req_s, grant_s, stall_s, slot_s;
    logic [CW-1:0]   cnt_s;
    logic [CW:0]     cnt_next_s;
    logic [2*XLEN-1:0] head_s;

    // request / stall / buffer control
    always_comb begin
        push_s     = (state_q == WAIT) && bus.imem_rvalid && !jp_en;
        pop_s      = bus.id_valid && bus.id_ready && !jp_en;
        cnt_next_s = {1'b0, cnt_s} + (CW+1)'(push_s) - (CW+1)'(pop_s);
        // the bus is free when idle or when the pending response lands now
        slot_s     = (state_q == IDLE) || bus.imem_rvalid;
        req_s      = rst && !jp_en && slot_s && (cnt_next_s < (CW+1)'(DEPTH));
        grant_s    = req_s && bus.imem_gnt;
        // a redirect must reach the PC register even with no grant
        stall_s    = !grant_s && !jp_en;
    end

    // FSM next state and captured request PC
    always_comb begin
        state_d = state_q;
        r_pc_d  = r_pc_q;
        if (grant_s) begin
            r_pc_d = pc_addr;
        end else begin
            r_pc_d = r_pc_q;
        end
        case (state_q)
            IDLE: state_d = grant_s ? WAIT : IDLE;
            WAIT: begin
                if (jp_en) begin
                    state_d = bus.imem_rvalid ? IDLE : DROP;
                end else if (bus.imem_rvalid) begin
                    state_d = grant_s ? WAIT : IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            DROP: begin
                if (bus.imem_rvalid) begin
                    state_d = grant_s ? WAIT : IDLE;
                end else begin
                    state_d = DROP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            r_pc_q  <= {XLEN{1'b0}};
        end else begin
            state_q <= state_d;
            r_pc_q  <= r_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (2*XLEN)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (jp_en),
        .din   ({r_pc_q, bus.imem_rdata}),
        .dout  (head_s),
        .cnt   (cnt_s)
    );

    if_fetch_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .state    (state_q),
        .rvalid   (bus.imem_rvalid),
        .jp_en    (jp_en),
        .pc_stall (pc_stall)
    );

    assign bus.imem_req  = req_s;
    assign bus.imem_addr = pc_addr;
    assign pc_stall      = stall_s;
    assign bus.id_valid  = (cnt_s != {CW{1'b0}});
    assign bus.id_pc     = head_s[2*XLEN-1:XLEN];
    assign bus.id_inst   = head_s[XLEN-1:0];

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: models the PC register and an in-order imem
// with configurable grant and latency, and scoreboards every decode handoff.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_addr;
    logic        pc_stall;
    logic        jp_en;

    always #5 clk = ~clk;

    if_fetch_if #(.XLEN(32)) bus ();

    if_fetch #(.DEPTH(2), .XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .pc_addr  (pc_addr),
        .pc_stall (pc_stall),
        .jp_en    (jp_en),
        .bus      (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic        rst_r, gnt_r, rdy_r, jp_r;
    logic [31:0] jp_tgt, pc_r, exp_pc;
    int          lat, cyc, n_cons;
    logic [31:0] rq_addr[$];
    int          rq_due[$];

    logic        s_req, s_stall, s_valid;
    logic [31:0] s_addr, s_pc, s_inst;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // One clock: drive at negedge, sample after settling, advance the models.
    task automatic cycle();
        @(negedge clk);
        rst          = rst_r;
        pc_addr      = pc_r;
        jp_en        = jp_r;
        bus.imem_gnt = gnt_r;
        bus.id_ready = rdy_r;
        if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = inst_of(rq_addr[0]);
            rq_due.delete(0);
            rq_addr.delete(0);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_stall = pc_stall;
        s_valid = bus.id_valid;
        s_pc    = bus.id_pc;
        s_inst  = bus.id_inst;
        if (rst_r && s_valid && rdy_r && !jp_r) begin
            check_val("cons_pc", 64'(s_pc), 64'(exp_pc));
            check_val("cons_inst", 64'(s_inst), 64'(inst_of(exp_pc)));
            exp_pc = exp_pc + 32'd4;
            n_cons++;
        end
        if (s_req && gnt_r) begin
            rq_addr.push_back(s_addr);
            rq_due.push_back(cyc + lat);
        end
        if (!rst_r) begin
            pc_r = 32'd0;
        end else if (jp_r) begin
            pc_r   = jp_tgt;
            exp_pc = jp_tgt;
        end else if (!s_stall) begin
            pc_r = pc_r + 32'd4;
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst_r = 1'b0; gnt_r = 1'b1; rdy_r = 1'b1; jp_r = 1'b0; lat = 1;
        rq_addr.delete();
        rq_due.delete();
        cycle();
        cycle();
        check_val("rst_valid", 64'(s_valid), 64'd0);
        check_val("rst_req", 64'(s_req), 64'd0);
        check_val("rst_stall", 64'(s_stall), 64'd1);
        rst_r  = 1'b1;
        exp_pc = 32'd0;
        n_cons = 0;
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] exp);
        int k = 0;
        cycle();
        while (!s_valid && k < 12) begin
            cycle();
            k++;
        end
        check_val({tag, "_valid"}, 64'(s_valid), 64'd1);
        check_val({tag, "_pc"}, 64'(s_pc), 64'(exp));
    endtask

    initial begin
        rst = 1'b0; pc_addr = 32'd0; jp_en = 1'b0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0; bus.id_ready = 1'b0;
        pc_r = 32'd0; jp_tgt = 32'd0; exp_pc = 32'd0; cyc = 0; n_cons = 0;

        // T1: zero-wait memory streams one instruction per cycle
        do_reset();
        cycle();
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_val("t1_valid", 64'(s_valid), 64'd1);
            check_val("t1_pc", 64'(s_pc), 64'(i * 4));
            check_val("t1_inst", 64'(s_inst), 64'(inst_of(32'(i * 4))));
        end

        // T2: decode back-pressure fills the buffer, PC freezes, then resumes
        do_reset();
        for (int i = 0; i < 5; i++) cycle();
        rdy_r = 1'b0;
        cycle();
        check_val("t2_c5_req", 64'(s_req), 64'd0);
        check_val("t2_c5_stall", 64'(s_stall), 64'd1);
        cycle();
        cycle();
        check_val("t2_valid", 64'(s_valid), 64'd1);
        check_val("t2_head", 64'(s_pc), 64'h0c);
        check_val("t2_req", 64'(s_req), 64'd0);
        check_val("t2_stall", 64'(s_stall), 64'd1);
        check_val("t2_addr", 64'(s_addr), 64'h14);
        rdy_r = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        check_val("t2_ncons", 64'(n_cons), 64'd9);

        // T3: grant withheld for three cycles
        do_reset();
        gnt_r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("t3_req", 64'(s_req), 64'd1);
            check_val("t3_addr", 64'(s_addr), 64'd0);
            check_val("t3_stall", 64'(s_stall), 64'd1);
        end
        gnt_r = 1'b1;
        cycle();
        check_val("t3_gnt_stall", 64'(s_stall), 64'd0);
        cycle();
        check_val("t3_next_addr", 64'(s_addr), 64'd4);
        check_val("t3_next_req", 64'(s_req), 64'd1);
        wait_valid("t3", 32'd0);

        // T4: redirect while a request is in flight, stale response dropped
        do_reset();
        lat   = 2;
        rdy_r = 1'b0;
        cycle();
        cycle();
        cycle();
        jp_r   = 1'b1;
        jp_tgt = 32'h100;
        cycle();
        check_val("t4_jp_stall", 64'(s_stall), 64'd0);
        check_val("t4_jp_req", 64'(s_req), 64'd0);
        check_val("t4_pre_valid", 64'(s_valid), 64'd1);
        check_val("t4_pre_pc", 64'(s_pc), 64'd0);
        jp_r  = 1'b0;
        rdy_r = 1'b1;
        cycle();
        check_val("t4_flush", 64'(s_valid), 64'd0);
        wait_valid("t4", 32'h100);

        // T5: redirect coincident with a response that would fill the buffer
        do_reset();
        rdy_r = 1'b0;
        cycle();
        cycle();
        jp_r   = 1'b1;
        jp_tgt = 32'h200;
        cycle();
        check_val("t5_stall", 64'(s_stall), 64'd0);
        check_val("t5_req", 64'(s_req), 64'd0);
        check_val("t5_pre_valid", 64'(s_valid), 64'd1);
        jp_r = 1'b0;
        cycle();
        check_val("t5_flush", 64'(s_valid), 64'd0);
        check_val("t5_idle_req", 64'(s_req), 64'd1);
        check_val("t5_addr", 64'(s_addr), 64'h200);
        rdy_r = 1'b1;
        wait_valid("t5", 32'h200);

        // T6: reset while waiting; the orphaned response must be ignored
        do_reset();
        lat = 3;
        cycle();
        rst_r = 1'b0;
        cycle();
        rst_r = 1'b1;
        gnt_r = 1'b0;
        cycle();
        check_val("t6_valid0", 64'(s_valid), 64'd0);
        check_val("t6_addr0", 64'(s_addr), 64'd0);
        cycle();
        cycle();
        check_val("t6_stale", 64'(s_valid), 64'd0);
        gnt_r = 1'b1;
        cycle();
        check_val("t6_req", 64'(s_req), 64'd1);
        check_val("t6_addr", 64'(s_addr), 64'd0);
        wait_valid("t6", 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
